// File: rtl/cpu_mem_bridge_if.sv
// cpu_mem_bridge_if: groups the core request/response signals and the
// 16-bit req/ack memory bus served by cpu_mem_bridge.
//   master : the surroundings (CPU core request side + memory fabric)
//   slave  : the bridge itself
// Parameter: ADDR_WIDTH - byte address width on both sides.
interface cpu_mem_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  // CPU side
  logic                  cpu_req_valid;
  logic                  cpu_req_we;
  logic [1:0]            cpu_req_size;
  logic [ADDR_WIDTH-1:0] cpu_req_addr;
  logic [47:0]           cpu_req_wdata;
  logic                  cpu_enable;
  logic [47:0]           cpu_rdata;
  logic                  cpu_err;
  // Memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [1:0]            mem_be;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_rdata;
  logic                  mem_ack;

  modport master (
    output cpu_req_valid, cpu_req_we, cpu_req_size, cpu_req_addr, cpu_req_wdata,
    input  cpu_enable, cpu_rdata, cpu_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );

  modport slave (
    input  cpu_req_valid, cpu_req_we, cpu_req_size, cpu_req_addr, cpu_req_wdata,
    output cpu_enable, cpu_rdata, cpu_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );
endinterface

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: takes the core's single outstanding 8/16/32/48-bit access,
// splits it into little-endian 16-bit beats on a req/ack memory bus, stalls
// the core via cpu_enable until the access completes and returns zero-extended
// read data (or an error for misaligned / timed-out accesses).
// Ports:
//   clk    - single clock, posedge
//   rst_n  - asynchronous active-low reset
//   bus    - cpu_mem_bridge_if.slave (CPU request/response + memory bus)
// Optional feature macro: CPU_MEM_BRIDGE_TIMEOUT_EN
//   defined   : a beat waiting TIMEOUT_CYCLES cycles without mem_ack is
//               abandoned and the access completes with cpu_err = 1
//   undefined : the bridge waits indefinitely for mem_ack
module cpu_mem_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic             clk,
  input logic             rst_n,
  cpu_mem_bridge_if.slave bus
);

  localparam int unsigned DATA_W = 48;
  localparam int unsigned BEAT_W = 16;
  localparam logic [1:0]  SZ8    = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_we;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [1:0]            r_beat;
  logic [1:0]            r_last_beat;
  logic [DATA_W-1:0]     r_rbuf;

  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [1:0]            r_mem_be;
  logic [BEAT_W-1:0]     r_mem_wdata;
  logic [DATA_W-1:0]     r_cpu_rdata;
  logic                  r_cpu_err;

  logic                  w_misaligned;
  logic                  w_last;
  logic [1:0]            w_beat_next;
  logic [DATA_W-1:0]     w_rbuf_next;

`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] r_wait;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Index of the final beat: 8/16 bit -> 0, 32 bit -> 1, 48 bit -> 2
  function automatic logic [1:0] f_last_beat(input logic [1:0] size);
    case (size)
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Halfword-aligned address of beat k
  function automatic logic [ADDR_WIDTH-1:0] f_beat_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [1:0] k);
    return {addr[ADDR_WIDTH-1:1], 1'b0} + ADDR_WIDTH'({k, 1'b0});
  endfunction

  // Byte accesses select one lane, everything else uses both
  function automatic logic [1:0] f_beat_be(input logic [1:0] size, input logic a0);
    if (size == SZ8) return a0 ? 2'b10 : 2'b01;
    return 2'b11;
  endfunction

  // Byte writes are replicated on both lanes; wider writes slice by beat
  function automatic logic [BEAT_W-1:0] f_beat_wdata(input logic [1:0] size,
                                                     input logic [DATA_W-1:0] wdata,
                                                     input logic [1:0] k);
    if (size == SZ8) return {wdata[7:0], wdata[7:0]};
    case (k)
      2'd0:    return wdata[15:0];
      2'd1:    return wdata[31:16];
      default: return wdata[47:32];
    endcase
  endfunction

  assign w_misaligned = (bus.cpu_req_size != SZ8) && bus.cpu_req_addr[0];
  assign w_last       = (r_beat == r_last_beat);
  assign w_beat_next  = 2'(r_beat + 2'd1);

  // Read buffer with the current beat's data merged in
  always_comb begin
    w_rbuf_next = r_rbuf;
    if (r_size == SZ8) begin
      w_rbuf_next = {40'd0, (r_addr[0] ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0])};
    end else begin
      case (r_beat)
        2'd0:    w_rbuf_next[15:0]  = bus.mem_rdata;
        2'd1:    w_rbuf_next[31:16] = bus.mem_rdata;
        default: w_rbuf_next[47:32] = bus.mem_rdata;
      endcase
    end
  end

  // Access sequencer: IDLE -> BEAT (one per 16-bit beat) -> DONE -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_beat      <= 2'd0;
      r_last_beat <= 2'd0;
      r_rbuf      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 2'b00;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
      r_cpu_err   <= 1'b0;
`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
      r_wait      <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cpu_req_valid) begin
            r_we        <= bus.cpu_req_we;
            r_size      <= bus.cpu_req_size;
            r_addr      <= bus.cpu_req_addr;
            r_wdata     <= bus.cpu_req_wdata;
            r_beat      <= 2'd0;
            r_last_beat <= f_last_beat(bus.cpu_req_size);
            r_rbuf      <= '0;
`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
            r_wait      <= '0;
`endif
            if (w_misaligned) begin
              // Rejected without touching memory
              r_state     <= ST_DONE;
              r_cpu_err   <= 1'b1;
              r_cpu_rdata <= '0;
            end else begin
              r_state     <= ST_BEAT;
              r_mem_req   <= 1'b1;
              r_mem_we    <= bus.cpu_req_we;
              r_mem_addr  <= f_beat_addr(bus.cpu_req_addr, 2'd0);
              r_mem_be    <= f_beat_be(bus.cpu_req_size, bus.cpu_req_addr[0]);
              r_mem_wdata <= f_beat_wdata(bus.cpu_req_size, bus.cpu_req_wdata, 2'd0);
            end
          end
        end

        ST_BEAT: begin
          if (bus.mem_ack) begin
            if (!r_we) r_rbuf <= w_rbuf_next;
            if (w_last) begin
              r_state     <= ST_DONE;
              r_mem_req   <= 1'b0;
              r_cpu_err   <= 1'b0;
              r_cpu_rdata <= r_we ? '0 : w_rbuf_next;
            end else begin
              // Next beat presented back-to-back, mem_req stays high
              r_beat      <= w_beat_next;
              r_mem_addr  <= f_beat_addr(r_addr, w_beat_next);
              r_mem_wdata <= f_beat_wdata(r_size, r_wdata, w_beat_next);
`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
              r_wait      <= '0;
`endif
            end
          end
`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
          else if (r_wait == TO_LAST) begin
            // Beat abandoned after TIMEOUT_CYCLES cycles of req without ack
            r_state     <= ST_DONE;
            r_mem_req   <= 1'b0;
            r_cpu_err   <= 1'b1;
            r_cpu_rdata <= '0;
          end else begin
            r_wait <= TO_W'(r_wait + 1'b1);
          end
`endif
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Stall is combinational in IDLE so the core halts in the request cycle
  assign bus.cpu_enable = !rst_n
                        || (r_state == ST_DONE)
                        || ((r_state == ST_IDLE) && !bus.cpu_req_valid);
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.cpu_err    = r_cpu_err;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_be     = r_mem_be;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule
